// File: rtl/alu_arbitro_if.sv
// Requester-side handshake bundle for alu_arbitro: one instance per client.
// The requester (master) drives req/sel/a/b; the arbiter (slave) returns gnt/done/res/err.
interface alu_arbitro_if #(
    parameter int WIDTH = 4,
    parameter int SELW  = 4
);
    logic             req;
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             err;

    modport master (
        output req, sel, a, b,
        input  gnt, done, res, err
    );

    modport slave (
        input  req, sel, a, b,
        output gnt, done, res, err
    );
endinterface

// File: rtl/alu_arbitro.sv
// Two-requester round-robin arbiter/sequencer for a shared combinational ALU.
// Operands are registered onto the ALU, the result is captured one cycle later.
module alu_arbitro #(
    parameter int WIDTH  = 4,
    parameter int SELW   = 4,
    parameter int MAX_OP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbitro_if.slave     rq0,
    alu_arbitro_if.slave     rq1,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_C,
    output logic             busy
);

    localparam logic [SELW-1:0] MAX_SEL = SELW'(MAX_OP);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   illegal;

    logic             win_valid;
    logic             winner;
    logic [SELW-1:0]  win_sel;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win_valid = rq0.req | rq1.req;
        winner    = 1'b0;
        if (rq0.req && rq1.req) begin
            winner = ~last;
        end else if (rq1.req) begin
            winner = 1'b1;
        end
        win_sel = winner ? rq1.sel : rq0.sel;
        win_a   = winner ? rq1.a   : rq0.a;
        win_b   = winner ? rq1.b   : rq0.b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            illegal  <= 1'b0;
            alu_A    <= '0;
            alu_B    <= '0;
            alu_sel  <= '0;
            busy     <= 1'b0;
            rq0.gnt  <= 1'b0;
            rq0.done <= 1'b0;
            rq0.res  <= '0;
            rq0.err  <= 1'b0;
            rq1.gnt  <= 1'b0;
            rq1.done <= 1'b0;
            rq1.res  <= '0;
            rq1.err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner <= winner;
                        // Illegal opcodes leave the ALU registers untouched.
                        if (win_sel <= MAX_SEL) begin
                            alu_A   <= win_a;
                            alu_B   <= win_b;
                            alu_sel <= win_sel;
                            illegal <= 1'b0;
                        end else begin
                            illegal <= 1'b1;
                        end
                        if (winner) begin
                            rq1.gnt <= 1'b1;
                        end else begin
                            rq0.gnt <= 1'b1;
                        end
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    rq0.gnt <= 1'b0;
                    rq1.gnt <= 1'b0;
                    if (owner) begin
                        rq1.res  <= illegal ? '0 : alu_C;
                        rq1.err  <= illegal;
                        rq1.done <= 1'b1;
                    end else begin
                        rq0.res  <= illegal ? '0 : alu_C;
                        rq0.err  <= illegal;
                        rq0.done <= 1'b1;
                    end
                    last  <= owner;
                    state <= RESP;
                end

                RESP: begin
                    rq0.done <= 1'b0;
                    rq1.done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
